// File: rtl/sdram_arb_pkg.sv
// Shared types and defaults for the SDRAM port arbiter.
// Holds the FSM state encoding (also exported on the debug port),
// the latched operation type and the default bus widths.
package sdram_arb_pkg;

  localparam int ADDR_W_DEF = 23;
  localparam int DATA_W_DEF = 32;

  // State encoding is visible on the debug port, so the values are fixed.
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ISSUE     = 3'd1,
    ST_WAIT_DATA = 3'd2,
    ST_DONE      = 3'd3
  } state_t;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_t;

endpackage

// File: rtl/sdram_arb_picker.sv
// Combinational winner select for the SDRAM port arbiter.
// Default: round robin, searching upward from ptr+1 modulo NUM_REQ.
// With SDRAM_ARB_FIXED_PRIO_EN defined: fixed priority, lowest index wins,
// and ptr is ignored.
module sdram_arb_picker #(
  parameter int NUM_REQ = 3,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);

`ifdef SDRAM_ARB_FIXED_PRIO_EN

  // Lowest asserted index wins; scanning downward lets the lowest overwrite.
  always_comb begin
    idx = '0;
    any = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx = IDX_W'(i);
        any = 1'b1;
      end
    end
  end

`else

  localparam logic [IDX_W:0] NUM_REQ_W = (IDX_W + 1)'(NUM_REQ);

  logic [IDX_W:0]     start_w;
  logic [IDX_W:0]     pos;
  logic [NUM_REQ-1:0] rot;

  // Rotate the request vector so bit 0 is the port just after the pointer,
  // then take the lowest set bit and map it back to a port index.
  always_comb begin
    start_w = {1'b0, ptr} + 1'b1;
    if (start_w >= NUM_REQ_W) begin
      start_w = '0;
    end
    rot = NUM_REQ'({req, req} >> start_w);
    pos = '0;
    idx = '0;
    any = |req;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (rot[k]) begin
        pos = start_w + (IDX_W + 1)'(k);
        if (pos >= NUM_REQ_W) begin
          pos = pos - NUM_REQ_W;
        end
        idx = pos[IDX_W-1:0];
      end
    end
  end

`endif

endmodule

// File: rtl/sdram_port_arbiter.sv
// Shares one SDRAM Avalon-MM master between NUM_REQ requesters
// (index 0 = mix core). One transaction is in flight at a time.
// Define SDRAM_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins)
// instead of the default round robin.
//
// Handshake: a requester raises req_read/req_write (level) with a stable
// address/data and holds it until its req_finished bit pulses for one cycle.
// Toward the SDRAM controller the command (av_read/av_write, address, data)
// is held constant while av_waitrequest=1 and is accepted on the first cycle
// with av_waitrequest=0; read data arrives later with av_readdatavalid=1.
module sdram_port_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF
) (
  input  logic                           i_clk,
  input  logic                           i_rst_n,
  input  logic [NUM_REQ-1:0]             req_read,
  input  logic [NUM_REQ-1:0]             req_write,
  input  logic [NUM_REQ-1:0][ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ-1:0][DATA_W-1:0] req_writedata,
  output logic [DATA_W-1:0]              req_readdata,
  output logic [NUM_REQ-1:0]             req_finished,
  output logic [ADDR_W-1:0]              av_address,
  output logic                           av_read,
  output logic                           av_write,
  output logic [DATA_W-1:0]              av_writedata,
  input  logic [DATA_W-1:0]              av_readdata,
  input  logic                           av_readdatavalid,
  input  logic                           av_waitrequest,
  output logic [2:0]                     debug
);

  localparam int              IDX_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

  state_t             state_q;
  state_t             state_d;
  logic [IDX_W-1:0]   grant_q;
  logic [IDX_W-1:0]   ptr;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_any;
  op_t                op_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [DATA_W-1:0]  wdata_q;
  logic [DATA_W-1:0]  rdata_q;
  logic [NUM_REQ-1:0] req_any;

  // A port requests when either read or write is raised.
  assign req_any = req_read | req_write;

  sdram_arb_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_picker (
    .req (req_any),
    .ptr (ptr),
    .idx (pick_idx),
    .any (pick_any)
  );

`ifdef SDRAM_ARB_FIXED_PRIO_EN
  // Fixed priority needs no history; the pointer is a constant.
  assign ptr = LAST_IDX;
`else
  logic [IDX_W-1:0] ptr_q;

  // Round-robin pointer: remembers the last served port, so it loses the next tie.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      ptr_q <= LAST_IDX;
    end else if (state_q == ST_DONE) begin
      ptr_q <= grant_q;
    end
  end

  assign ptr = ptr_q;
`endif

  // FSM state register.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and command/completion outputs, all decoded from the state.
  always_comb begin
    state_d      = state_q;
    av_read      = 1'b0;
    av_write     = 1'b0;
    req_finished = '0;
    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        av_read  = (op_q == OP_READ);
        av_write = (op_q == OP_WRITE);
        if (!av_waitrequest) begin
          state_d = (op_q == OP_WRITE) ? ST_DONE : ST_WAIT_DATA;
        end
      end
      ST_WAIT_DATA: begin
        if (av_readdatavalid) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        // Requests are not looked at here; a held request is re-arbitrated
        // from IDLE with whatever address the requester presents by then.
        req_finished[grant_q] = 1'b1;
        state_d               = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Transaction latch at grant time, plus the shared read-data register.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      grant_q <= '0;
      op_q    <= OP_READ;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      if (state_q == ST_IDLE && pick_any) begin
        grant_q <= pick_idx;
        // Read and write together on one port is served as a write.
        op_q    <= req_write[pick_idx] ? OP_WRITE : OP_READ;
        addr_q  <= req_addr[pick_idx];
        wdata_q <= req_writedata[pick_idx];
      end
      // Read data persists across writes until the next read completes.
      if (state_q == ST_WAIT_DATA && av_readdatavalid) begin
        rdata_q <= av_readdata;
      end
    end
  end

  assign av_address   = addr_q;
  assign av_writedata = wdata_q;
  assign req_readdata = rdata_q;
  assign debug        = state_q;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Testbench for sdram_port_arbiter: directed steps followed by randomized
// traffic, checked against a behavioural model of arbitration and memory.
module tb_sdram_port_arbiter;

  localparam int NUM_REQ = 3;
  localparam int ADDR_W  = 23;
  localparam int DATA_W  = 32;

  // ---------------- clock / reset ----------------
  logic i_clk = 1'b0;
  logic i_rst_n = 1'b0;
  always #5 i_clk = ~i_clk;

  logic [NUM_REQ-1:0]             req_read;
  logic [NUM_REQ-1:0]             req_write;
  logic [NUM_REQ-1:0][ADDR_W-1:0] req_addr;
  logic [NUM_REQ-1:0][DATA_W-1:0] req_writedata;
  logic [DATA_W-1:0]              req_readdata;
  logic [NUM_REQ-1:0]             req_finished;
  logic [ADDR_W-1:0]              av_address;
  logic                           av_read;
  logic                           av_write;
  logic [DATA_W-1:0]              av_writedata;
  logic [DATA_W-1:0]              av_readdata;
  logic                           av_readdatavalid;
  logic                           av_waitrequest;
  logic [2:0]                     debug;

  sdram_port_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W)
  ) dut (
    .i_clk            (i_clk),
    .i_rst_n          (i_rst_n),
    .req_read         (req_read),
    .req_write        (req_write),
    .req_addr         (req_addr),
    .req_writedata    (req_writedata),
    .req_readdata     (req_readdata),
    .req_finished     (req_finished),
    .av_address       (av_address),
    .av_read          (av_read),
    .av_write         (av_write),
    .av_writedata     (av_writedata),
    .av_readdata      (av_readdata),
    .av_readdatavalid (av_readdatavalid),
    .av_waitrequest   (av_waitrequest),
    .debug            (debug)
  );

  // ---------------- model state ----------------
  int checks = 0;
  int failures = 0;
  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] mem [logic [ADDR_W-1:0]];
  logic [DATA_W-1:0] last_rd;
  int model_ptr;
  bit rd_r [NUM_REQ];
  bit wr_r [NUM_REQ];
  logic [ADDR_W-1:0] a_r [NUM_REQ];
  logic [DATA_W-1:0] d_r [NUM_REQ];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] memval(input logic [ADDR_W-1:0] a);
    if (mem.exists(a)) return mem[a];
    return {9'h0, a} ^ 32'hC0DE_0000;
  endfunction

  function automatic logic [NUM_REQ-1:0] cur_vec();
    logic [NUM_REQ-1:0] v;
    for (int i = 0; i < NUM_REQ; i++) v[i] = rd_r[i] | wr_r[i];
    return v;
  endfunction

  // Winner by the arbitration rule, from the set of requesting ports.
  function automatic int model_pick(input logic [NUM_REQ-1:0] v, input int ptr);
`ifdef SDRAM_ARB_FIXED_PRIO_EN
    for (int i = 0; i < NUM_REQ; i++) if (((v >> i) & 1) != 0) return i;
`else
    for (int k = 1; k <= NUM_REQ; k++) begin
      int p = (ptr + k) % NUM_REQ;
      if (((v >> p) & 1) != 0) return p;
    end
`endif
    return -1;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic apply();
    for (int i = 0; i < NUM_REQ; i++) begin
      req_read[i]      = rd_r[i];
      req_write[i]     = wr_r[i];
      req_addr[i]      = a_r[i];
      req_writedata[i] = d_r[i];
    end
  endtask

  task automatic clear_port(input int p);
    rd_r[p] = 1'b0;
    wr_r[p] = 1'b0;
  endtask

  // Acts as SDRAM controller for one transaction and checks it end to end.
  // Returns at the negedge of the completion cycle; n = idle negedges seen.
  task automatic run_txn(input int port, input bit is_wr, input logic [ADDR_W-1:0] addr,
                         input logic [DATA_W-1:0] wdata, input int stall, input int lat,
                         output int n);
    bit seen = 1'b0;
    logic [DATA_W-1:0] rd;
    n = 0;
    for (int w = 0; w < 20; w++) begin
      @(negedge i_clk);
      if (av_read || av_write) begin
        seen = 1'b1;
        break;
      end
      chk("fin_idle", 32'(req_finished), 32'd0);
      n++;
    end
    chk("issue_seen", 32'(seen), 32'd1);
    if (!seen) return;
    chk("av_write", 32'(av_write), 32'(is_wr));
    chk("av_read", 32'(av_read), 32'(!is_wr));
    chk("av_addr", 32'(av_address), 32'(addr));
    if (is_wr) chk("av_wdata", av_writedata, wdata);
    chk("debug_issue", 32'(debug), 32'd1);
    av_waitrequest = (stall > 0);
    for (int s = 0; s < stall; s++) begin
      @(negedge i_clk);
      chk("stall_write", 32'(av_write), 32'(is_wr));
      chk("stall_read", 32'(av_read), 32'(!is_wr));
      chk("stall_addr", 32'(av_address), 32'(addr));
      if (is_wr) chk("stall_wdata", av_writedata, wdata);
      if (s == stall - 1) av_waitrequest = 1'b0;
    end
    if (is_wr) begin
      @(negedge i_clk);
      mem[addr] = wdata;
      chk("rdata_hold", req_readdata, last_rd);
    end else begin
      rd = memval(addr);
      @(negedge i_clk);
      chk("wait_no_read", 32'(av_read), 32'd0);
      chk("debug_wait", 32'(debug), 32'd2);
      for (int l = 1; l < lat; l++) @(negedge i_clk);
      av_readdatavalid = 1'b1;
      av_readdata      = rd;
      exp_q.push_back(rd);
      @(negedge i_clk);
      av_readdatavalid = 1'b0;
      av_readdata      = $urandom;
      if (exp_q.size() > 0) chk("rdata", req_readdata, exp_q.pop_front());
      last_rd = rd;
    end
    chk("fin_pulse", 32'(req_finished), 32'd1 << port);
    chk("debug_done", 32'(debug), 32'd3);
    model_ptr = port;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_av_read"}, 32'(av_read), 32'd0);
    chk({tag, "_av_write"}, 32'(av_write), 32'd0);
    chk({tag, "_av_addr"}, 32'(av_address), 32'd0);
    chk({tag, "_av_wdata"}, av_writedata, 32'd0);
    chk({tag, "_fin"}, 32'(req_finished), 32'd0);
    chk({tag, "_rdata"}, req_readdata, 32'd0);
    chk({tag, "_debug"}, 32'(debug), 32'd0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed + random steps ----------------
  initial begin
    int n, p, r;
    logic [NUM_REQ-1:0] v;
    for (int i = 0; i < NUM_REQ; i++) begin
      rd_r[i] = 1'b0; wr_r[i] = 1'b0; a_r[i] = '0; d_r[i] = '0;
    end
    apply();
    av_readdata = '0; av_readdatavalid = 1'b0; av_waitrequest = 1'b0;
    last_rd = '0;
    model_ptr = NUM_REQ - 1;
    mem[23'h000010] = 32'hDEADBEEF;

    // Reset state.
    repeat (3) @(negedge i_clk);
    chk_all_zero("reset");
    i_rst_n = 1'b1;

    // Single read on port 0, data one cycle after acceptance.
    rd_r[0] = 1'b1; a_r[0] = 23'h000010; apply();
    run_txn(model_pick(cur_vec(), model_ptr), 1'b0, 23'h000010, '0, 0, 1, n);
    chk("read_latency", 32'(n), 32'd0);
    chk("read_data_lit", req_readdata, 32'hDEADBEEF);
    clear_port(0); apply();
    @(negedge i_clk);
    chk("read_fin_once", 32'(req_finished), 32'd0);

    // Stalled write on port 1: command stable for four cycles.
    wr_r[1] = 1'b1; a_r[1] = 23'h7FFFFF; d_r[1] = 32'h12345678; apply();
    run_txn(model_pick(cur_vec(), model_ptr), 1'b1, 23'h7FFFFF, 32'h12345678, 3, 1, n);
    clear_port(1); apply();
    @(negedge i_clk);
    chk("write_fin_once", 32'(req_finished), 32'd0);

    // Read and write together on port 2 is a write.
    rd_r[2] = 1'b1; wr_r[2] = 1'b1; a_r[2] = 23'h000005; d_r[2] = 32'hAABBCCDD; apply();
    p = model_pick(cur_vec(), model_ptr);
    chk("rw_pick", 32'(p), 32'd2);
    run_txn(p, 1'b1, 23'h000005, 32'hAABBCCDD, 1, 1, n);
    clear_port(2); apply();

    // Back-to-back on port 0: new address presented at finished.
    rd_r[0] = 1'b1; a_r[0] = 23'h000100; apply();
    run_txn(0, 1'b0, 23'h000100, '0, 0, 2, n);
    a_r[0] = 23'h000200; apply();
    run_txn(0, 1'b0, 23'h000200, '0, 0, 1, n);
    chk("b2b_latency", 32'(n), 32'd1);
    clear_port(0); apply();

    // Reset during WAIT_DATA abandons the read.
    rd_r[0] = 1'b1; a_r[0] = 23'h000040; apply();
    for (int w = 0; w < 10 && !av_read; w++) @(negedge i_clk);
    av_waitrequest = 1'b0;
    @(negedge i_clk);
    chk("pre_reset_wait", 32'(debug), 32'd2);
    i_rst_n = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin rd_r[i] = 1'b1; a_r[i] = 23'(16 + i); end
    apply();
    @(negedge i_clk);
    chk_all_zero("midreset");
    i_rst_n = 1'b1;
    model_ptr = NUM_REQ - 1;
    last_rd = '0;

    // Contention: all ports read continuously.
    for (int t = 0; t < 6; t++) begin
      p = model_pick(cur_vec(), model_ptr);
`ifdef SDRAM_ARB_FIXED_PRIO_EN
      chk("contend_order", 32'(p), 32'd0);
`else
      chk("contend_order", 32'(p), 32'(t % NUM_REQ));
`endif
      run_txn(p, 1'b0, a_r[p], '0, 0, 1, n);
      if (t == 0) chk("post_reset_latency", 32'(n), 32'd0);
      a_r[p] = 23'($urandom_range(0, 15));
      apply();
    end
    for (int i = 0; i < NUM_REQ; i++) clear_port(i);
    apply();

    // Randomized traffic.
    for (int t = 0; t < 40; t++) begin
      v = cur_vec();
      if (v == '0) begin
        r = $urandom_range(0, NUM_REQ - 1);
        rd_r[r] = 1'b1; a_r[r] = 23'($urandom_range(0, 15));
        apply();
        v = cur_vec();
      end
      p = model_pick(v, model_ptr);
      run_txn(p, wr_r[p], a_r[p], d_r[p], $urandom_range(0, 3), $urandom_range(1, 3), n);
      // Finished port picks a new request; idle ports may start one.
      for (int i = 0; i < NUM_REQ; i++) begin
        if (i == p || !(rd_r[i] | wr_r[i])) begin
          r = $urandom_range(0, 9);
          rd_r[i] = (r >= 3 && r < 6) || r == 9;
          wr_r[i] = (r >= 6);
          a_r[i]  = 23'($urandom_range(0, 15));
          d_r[i]  = $urandom;
        end
      end
      apply();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
